// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : Parametrised APB slave register file with programmable wait
//            states, byte write strobes, error response and a read-only
//            register region fed from hardware.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   bus clock, rising edge active
//   rst      in   asynchronous active-low reset
//   p_sel    in   slave select
//   p_en     in   access-phase enable
//   p_write  in   1 = write, 0 = read
//   addr     in   [AWIDTH]        byte address
//   wdata    in   [DWIDTH]        write data
//   p_strb   in   [DWIDTH/8]      byte write strobes
//   rdata    out  [DWIDTH]        read data (valid in ready cycle of a read)
//   p_ready  out  transfer complete
//   p_slverr out  error response (qualified by p_ready)
//   ro_in    in   [(DEPTH-RO_BASE)*DWIDTH]  values of the read-only registers
//   reg_q    out  [DEPTH*DWIDTH]  flattened register contents
// ============================================================================
module apb_slave_regfile #(
  parameter int                AWIDTH      = 8,
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH       = 16,
  parameter int                RO_BASE     = 12,
  parameter int                WAIT_STATES = 0,
  parameter logic [DWIDTH-1:0] RST_VAL     = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                p_sel,
  input  logic                                p_en,
  input  logic                                p_write,
  input  logic [AWIDTH-1:0]                   addr,
  input  logic [DWIDTH-1:0]                   wdata,
  input  logic [DWIDTH/8-1:0]                 p_strb,
  output logic [DWIDTH-1:0]                   rdata,
  output logic                                p_ready,
  output logic                                p_slverr,
  input  logic [(DEPTH-RO_BASE)*DWIDTH-1:0]   ro_in,
  output logic [DEPTH*DWIDTH-1:0]             reg_q
);

  localparam int                NB         = DWIDTH / 8;
  localparam int                OFFW       = $clog2(NB);
  localparam int                IW         = AWIDTH - OFFW;
  localparam logic [IW:0]       C_DEPTH    = (IW+1)'(DEPTH);
  localparam logic [IW:0]       C_RO_BASE  = (IW+1)'(RO_BASE);
  localparam logic [3:0]        C_WAIT     = 4'(WAIT_STATES);
  localparam logic [AWIDTH-1:0] C_OFF_MASK = AWIDTH'(NB - 1);

  // The setup phase is the cycle spent in IDLE while p_sel=1, p_en=0; the
  // capture happens on the setup->access edge, so an unwaited transfer
  // completes in two bus cycles.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;

  logic [IW:0]         w_idx_q;      // index of the captured transfer
  logic [IW:0]         w_idx_d;      // index of the transfer about to be ready
  logic                w_err;
  logic                w_rd_err_d;
  logic                w_commit;
  logic [DWIDTH-1:0]   w_rd_word;

  assign w_idx_q = {1'b0, addr_q[AWIDTH-1:OFFW]};
  assign w_idx_d = {1'b0, addr_d[AWIDTH-1:OFFW]};

  assign w_err = (w_idx_q >= C_DEPTH) || (|(addr_q & C_OFF_MASK)) ||
                 (write_q && (w_idx_q >= C_RO_BASE));

  assign p_ready  = rst && (state_q == ST_ACCESS) && p_sel && p_en && (cnt_q == 4'd0);
  assign p_slverr = p_ready && w_err;
  assign w_commit = p_ready && write_q && !w_err;
  assign rdata    = rdata_q;

  // Next-state, capture and read-data selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    w_rd_word  = '0;
    w_rd_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // p_en without a preceding setup phase is ignored here.
        if (p_sel && !p_en) begin
          state_d = ST_ACCESS;
          cnt_d   = C_WAIT;
          addr_d  = addr;
          write_d = p_write;
          wdata_d = wdata;
          strb_d  = p_strb;
        end
      end
      ST_ACCESS: begin
        if (!(p_sel && p_en)) begin
          state_d = ST_IDLE;      // protocol violation: abandon the transfer
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;      // next setup phase is recognised from IDLE
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // rdata is loaded on the edge that enters the ready cycle of a read, so
    // the address used is the one that will be held during that cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (w_idx_d == (IW+1)'(i)) w_rd_word = reg_q[i*DWIDTH +: DWIDTH];
    end
    w_rd_err_d = (w_idx_d >= C_DEPTH) || (|(addr_d & C_OFF_MASK));
    if ((state_d == ST_ACCESS) && (cnt_d == 4'd0) && !write_d) begin
      rdata_d = w_rd_err_d ? '0 : w_rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
    end
  end

  // Register storage for the R/W region; read-only slots mirror ro_in.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i < RO_BASE) begin : g_rw
      logic [DWIDTH-1:0] word_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_q <= RST_VAL;
        end else if (w_commit && (w_idx_q == (IW+1)'(i))) begin
          for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) word_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
      assign reg_q[i*DWIDTH +: DWIDTH] = word_q;
    end else begin : g_ro
      assign reg_q[i*DWIDTH +: DWIDTH] = ro_in[(i-RO_BASE)*DWIDTH +: DWIDTH];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Directed bench for apb_slave_regfile. Two instances share the bus
//            (WAIT_STATES=0 and WAIT_STATES=3) with separate selects. Each
//            transfer pushes its expected response; a monitor pops and
//            compares whenever either instance raises p_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   sel;
  logic         p_en, p_write;
  logic [7:0]   addr;
  logic [31:0]  wdata;
  logic [3:0]   p_strb;
  logic [127:0] ro_in;

  logic [31:0]  rdata0, rdata3;
  logic         rdy0, rdy3, serr0, serr3;
  logic [511:0] regq0, regq3;

  apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .p_sel(sel[0]), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .p_strb(p_strb), .rdata(rdata0),
    .p_ready(rdy0), .p_slverr(serr0), .ro_in(ro_in), .reg_q(regq0)
  );

  apb_slave_regfile #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .p_sel(sel[1]), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .p_strb(p_strb), .rdata(rdata3),
    .p_ready(rdy3), .p_slverr(serr3), .ro_in(ro_in), .reg_q(regq3)
  );

  typedef struct {
    int          which;
    bit          wr;
    bit          err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   chk  = 0;
  int   errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int which, input int idx);
    return (which != 0) ? regq3[idx*32 +: 32] : regq0[idx*32 +: 32];
  endfunction

  // Monitor: one sample per cycle, mid-cycle, after stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rdy0 || rdy3) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {31'd0, rdy3}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("ready_port", {31'd0, rdy3}, e.which);
          check("slverr", {31'd0, (e.which != 0) ? serr3 : serr0}, {31'd0, e.err});
          if (!e.wr) check("rdata", (e.which != 0) ? rdata3 : rdata0, e.rd);
        end
      end
    end
  end

  // One APB transfer, entered and left on a falling edge. cyc counts the
  // setup cycle plus every access cycle up to and including the ready one;
  // pre is the addressed register word as seen just before the ready edge.
  task automatic xfer(input int which, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit exp_err, input logic [31:0] exp_rd,
                      input bit b2b, output int cyc, output logic [31:0] pre);
    bit got;
    exp_q.push_back('{which, wr, exp_err, exp_rd});
    sel        = 2'b00;
    sel[which] = 1'b1;
    p_en = 1'b0; p_write = wr; addr = a; wdata = d; p_strb = s;
    cyc = 1;
    pre = '0;
    got = 1'b0;
    @(negedge clk);
    p_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc++;
      #1;
      if ((which != 0) ? rdy3 : rdy0) begin
        got = 1'b1;
        pre = word_of(which, int'(a[5:2]));
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    @(negedge clk);
    if (!b2b) begin
      sel = 2'b00; p_en = 1'b0;
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] pre;
    logic [383:0] snap;

    rst = 1'b0; sel = 2'b00; p_en = 1'b0; p_write = 1'b0;
    addr = '0; wdata = '0; p_strb = '0;
    ro_in = {32'h0000_0003, 32'h0000_0002, 32'h1234_5678, 32'hCAFE_F00D};

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, rdy0}, 32'd0);
    check("rst_slverr", {31'd0, serr0}, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_reg0", word_of(0, 0), 32'd0);
    check("rst_reg11", word_of(0, 11), 32'd0);
    check("ro_mirror12", word_of(0, 12), 32'hCAFE_F00D);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: first read after reset
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0000_0000, 1'b0, cyc, pre);
    check("t1_cycles", cyc, 32'd2);

    // 2: full write then partial write
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0, 1'b0, cyc, pre);
    xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'b0101, 1'b0, 32'h0, 1'b0, cyc, pre);
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, 1'b0, cyc, pre);
    check("t2_regq1", regq0[63:32], 32'hDE22_BE44);

    // zero-strobe write: legal, no change
    xfer(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, 1'b0, cyc, pre);
    check("strb0_regq1", regq0[63:32], 32'hDE22_BE44);

    // 3: three wait states
    xfer(1, 1'b1, 8'h08, 32'hA5A5_5A5A, 4'b1111, 1'b0, 32'h0, 1'b0, cyc, pre);
    check("t3_cycles", cyc, 32'd5);
    check("t3_pre_commit", pre, 32'd0);
    check("t3_post_commit", regq3[95:64], 32'hA5A5_5A5A);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'hA5A5_5A5A, 1'b0, cyc, pre);
    check("t3_read_cycles", cyc, 32'd5);

    // 4: error responses
    snap = regq0[383:0];
    xfer(0, 1'b1, 8'h40, 32'h0BAD_0BAD, 4'b1111, 1'b1, 32'h0, 1'b0, cyc, pre);
    check("t4_oor_nochange", {31'd0, regq0[383:0] == snap}, 32'd1);
    xfer(0, 1'b1, 8'h30, 32'h0BAD_0BAD, 4'b1111, 1'b1, 32'h0, 1'b0, cyc, pre);
    check("t4_ro_nochange", {31'd0, regq0[383:0] == snap}, 32'd1);
    check("t4_ro_mirror", regq0[415:384], 32'hCAFE_F00D);
    xfer(0, 1'b0, 8'h02, 32'h0, 4'h0, 1'b1, 32'h0000_0000, 1'b0, cyc, pre);
    xfer(0, 1'b0, 8'h44, 32'h0, 4'h0, 1'b1, 32'h0000_0000, 1'b0, cyc, pre);

    // 5: read-only region reads
    xfer(0, 1'b0, 8'h30, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b0, cyc, pre);
    xfer(0, 1'b0, 8'h34, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0, cyc, pre);

    // 6a: back-to-back write then read with no idle cycle
    xfer(0, 1'b1, 8'h0C, 32'h0BAD_C0DE, 4'b1111, 1'b0, 32'h0, 1'b1, cyc, pre);
    xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h0BAD_C0DE, 1'b0, cyc, pre);
    check("t6_b2b_cycles", cyc, 32'd2);

    // protocol violation: p_en without setup does nothing
    sel = 2'b01; p_en = 1'b1; p_write = 1'b1; addr = 8'h00;
    wdata = 32'hFFFF_FFFF; p_strb = 4'hF;
    #1;
    check("viol_ready_a", {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    #1;
    check("viol_ready_b", {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    sel = 2'b00; p_en = 1'b0;
    @(negedge clk);
    check("viol_reg0", word_of(0, 0), 32'd0);

    // 6b: reset asserted during the ready cycle of a write
    sel = 2'b01; p_en = 1'b0; p_write = 1'b1; addr = 8'h10;
    wdata = 32'h5555_5555; p_strb = 4'hF;
    @(negedge clk);
    p_en = 1'b1;
    #1;
    check("t6_ready_before_rst", {31'd0, rdy0}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_ready_in_rst", {31'd0, rdy0}, 32'd0);
    check("t6_slverr_in_rst", {31'd0, serr0}, 32'd0);
    @(negedge clk);
    sel = 2'b00; p_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_reg4_rst", word_of(0, 4), 32'd0);
    check("t6_reg3_rst", word_of(0, 3), 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end

endmodule
`default_nettype wire
